// File: rtl/rv32m_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to let div-by-zero and overflow skip CALC.
module rv32m_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic            neg_q;
    logic            neg_r;
    logic            div0_q;
    logic            ovf_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] q_q;
    logic [XLEN:0]   rem_q;
    logic [4:0]      cnt_q;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            is_div0;
    logic            is_ovf;
    logic            skip;
    logic [XLEN:0]   t_a;
    logic [XLEN+1:0] t_sum;
    logic            borrow;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rmd;
    logic [XLEN-1:0] fin_val;
    logic            unused_bits;

    // Operand conditioning for the request presented in IDLE
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & dividend[XLEN-1];
        b_neg     = signed_op & divisor[XLEN-1];
        a_abs     = a_neg ? -dividend : dividend;
        b_abs     = b_neg ? -divisor : divisor;
        is_div0   = (divisor == '0);
        is_ovf    = signed_op
                  & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  & (divisor == '1);
`ifdef DIV_EARLY_OUT_EN
        skip      = is_div0 | is_ovf;
`else
        skip      = 1'b0;
`endif
    end

    // Trial subtraction as complement-and-add; carry-out set means no borrow
    always_comb begin
        t_a    = {rem_q[XLEN-1:0], q_q[XLEN-1]};
        t_sum  = {1'b0, t_a} + {1'b0, ~{1'b0, b_q}} + 1'b1;
        borrow = ~t_sum[XLEN+1];
    end

    // Sign fix-up, op select and RISC-V special-case overrides
    always_comb begin
        quo = neg_q ? -q_q : q_q;
        rmd = neg_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (div0_q)
            fin_val = op_q[1] ? a_q : '1;
        else if (ovf_q)
            fin_val = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else
            fin_val = op_q[1] ? rmd : quo;
    end

    // Top bit of the remainder never survives a non-borrowing step
    assign unused_bits = rem_q[XLEN];

    assign busy = (state != S_IDLE);

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            q_q    <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0_q <= is_div0;
                        ovf_q  <= is_ovf;
                        a_q    <= dividend;
                        b_q    <= b_abs;
                        q_q    <= a_abs;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        state  <= skip ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    if (borrow) begin
                        rem_q <= t_a;
                        q_q   <= {q_q[XLEN-2:0], 1'b0};
                    end else begin
                        rem_q <= t_sum[XLEN:0];
                        q_q   <= {q_q[XLEN-2:0], 1'b1};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state <= S_FIN;
                end
                S_FIN: begin
                    result <= fin_val;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
